// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared baud codes, divider constants, frame length and FSM
//               state type for the byte-wide UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_e;

    localparam int C_DIV_W = 13;

    localparam logic [C_DIV_W-1:0] C_DIV_9600   = 13'd5208;
    localparam logic [C_DIV_W-1:0] C_DIV_19200  = 13'd2604;
    localparam logic [C_DIV_W-1:0] C_DIV_38400  = 13'd1302;
    localparam logic [C_DIV_W-1:0] C_DIV_57600  = 13'd868;
    localparam logic [C_DIV_W-1:0] C_DIV_115200 = 13'd434;

    localparam int C_FRAME_BITS = 10;
    localparam int C_BIT_CNT_W  = $clog2(C_FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GUARD_WAIT = 2'd1,
        ST_SHIFT      = 2'd2
    } tx_state_e;

    // Codes 5..7 fall through to the fastest rate.
    function automatic logic [C_DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                     input logic [2:0]  code);
        logic        at_ref;
        logic [C_DIV_W-1:0] div;
        at_ref = (clk_freq == 32'd50_000_000);
        case (code)
            BAUD_9600:  div = at_ref ? C_DIV_9600  : C_DIV_W'(clk_freq / 32'd9600);
            BAUD_19200: div = at_ref ? C_DIV_19200 : C_DIV_W'(clk_freq / 32'd19200);
            BAUD_38400: div = at_ref ? C_DIV_38400 : C_DIV_W'(clk_freq / 32'd38400);
            BAUD_57600: div = at_ref ? C_DIV_57600 : C_DIV_W'(clk_freq / 32'd57600);
            default:    div = at_ref ? C_DIV_115200 : C_DIV_W'(clk_freq / 32'd115200);
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx_if
// Description : Request/data/serial-line bundle between a byte source and
//               the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_byte_tx_if;
    logic       send_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       uart_tx;
    logic       tx_done;
    logic       uart_state;

    modport master (
        output send_en, data_byte, baud_set,
        input  uart_tx, tx_done, uart_state
    );

    modport slave (
        input  send_en, data_byte, baud_set,
        output uart_tx, tx_done, uart_state
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_div.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_div
// Description : Bit-period counter; strobes o_bit_tick on the last clock of
//               each bit while enabled, and holds at zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_div
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [C_DIV_W-1:0] i_div,
    output logic               o_bit_tick
);

    logic [C_DIV_W-1:0] cnt_q, cnt_d;

    assign o_bit_tick = i_en && (cnt_q == (i_div - 1'b1));

    always_comb begin
        cnt_d = '0;
        if (i_en) begin
            cnt_d = o_bit_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 UART byte transmitter with latched rate select and a
//               guard gap between frames for the upstream RAM read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned GUARD    = 3
) (
    input  logic          clk,
    input  logic          reset,
    uart_byte_tx_if.slave tx_if
);

    // The tick edge that raises tx_done already counts as the first guard clock.
    localparam int C_GUARD_W = (GUARD > 2) ? $clog2(GUARD) : 1;
    localparam logic [C_GUARD_W-1:0] C_GUARD_LAST =
        C_GUARD_W'((GUARD > 2) ? GUARD - 2 : 0);
    localparam bit C_SKIP_GUARD = (GUARD < 2);
    localparam logic [C_BIT_CNT_W-1:0] C_LAST_BIT = C_BIT_CNT_W'(C_FRAME_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [C_DIV_W-1:0]        div_q, div_d;
    logic [C_FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [C_BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [C_GUARD_W-1:0]      guard_q, guard_d;
    logic                      uart_tx_q, uart_tx_d;
    logic                      tx_done_q, tx_done_d;
    logic                      busy_q, busy_d;
    logic                      w_shift;
    logic                      w_bit_tick;

    assign w_shift = (state_q == ST_SHIFT);

    uart_baud_div u_baud_div (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_shift),
        .i_div      (div_q),
        .o_bit_tick (w_bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        guard_d   = guard_q;
        uart_tx_d = 1'b1;
        tx_done_d = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_if.send_en) begin
                    state_d   = ST_SHIFT;
                    div_d     = baud_div(CLK_FREQ, tx_if.baud_set);
                    shreg_d   = {1'b1, tx_if.data_byte, 1'b0};
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                // Output lags the shifter by one clock so bit k starts at N+1+k*DIV.
                uart_tx_d = shreg_q[0];
                busy_d    = 1'b1;
                if (w_bit_tick) begin
                    shreg_d = {1'b1, shreg_q[C_FRAME_BITS-1:1]};
                    if (bit_cnt_q == C_LAST_BIT) begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = '0;
                        guard_d   = '0;
                        state_d   = C_SKIP_GUARD ? ST_IDLE : ST_GUARD_WAIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_GUARD_WAIT: begin
                if (guard_q == C_GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            guard_q   <= '0;
            uart_tx_q <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            guard_q   <= guard_d;
            uart_tx_q <= uart_tx_d;
            tx_done_q <= tx_done_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_if.uart_tx    = uart_tx_q;
    assign tx_if.tx_done    = tx_done_q;
    assign tx_if.uart_state = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_byte_tx
// Description : Self-checking bench: frames decoded off the line are scored
//               against expectations queued when each request is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    int         cyc      = 0;
    int         total    = 0;
    int         bad      = 0;
    int         done_cnt = 0;
    logic [7:0] drv_data = 8'h00;
    logic       use_ram  = 1'b0;
    logic       ram_clr  = 1'b1;
    logic [7:0] ram [4];
    logic [1:0] ram_addr;
    logic [7:0] ram_dout;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         start;
    } exp_t;

    typedef struct {
        logic [2:0] baud;
        logic [7:0] data;
        int         div;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[3];

    uart_byte_tx_if tb_if();

    assign tb_if.data_byte = use_ram ? ram_dout : drv_data;

    uart_byte_tx #(
        .CLK_FREQ (50_000_000),
        .GUARD    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tx_if (tb_if)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Model RAM: address steps one clock after tx_done, data one clock later.
    always @(posedge clk) begin
        if (ram_clr) ram_addr <= 2'd0;
        else if (tb_if.tx_done) ram_addr <= ram_addr + 2'd1;
        ram_dout <= ram[ram_addr];
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tb_if.tx_done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no tx_done within %0d cycles, required one pulse", nm, budget);
        end
    endtask

    task automatic send_pulse(input logic [2:0] b, input logic [7:0] d, input int div,
                              output int n);
        @(negedge clk);
        tb_if.baud_set = b;
        drv_data       = d;
        tb_if.send_en  = 1'b1;
        n = cyc + 1;
        sb.push_back('{d, div, n + 1});
        @(negedge clk);
        tb_if.send_en = 1'b0;
    endtask

    // Line decoder: every sample of a frame is checked against the queued record.
    initial begin : monitor
        bit         in_frame;
        int         start, div, j, bit_err, st_err, done_err;
        logic [9:0] fr;
        exp_t       e;
        in_frame = 1'b0;
        start = 0; div = 434; bit_err = 0; st_err = 0; done_err = 0;
        fr = 10'h3FF;
        forever begin
            @(negedge clk);
            if (tb_if.tx_done) done_cnt++;
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tb_if.uart_tx == 1'b0) begin
                    start    = cyc;
                    in_frame = 1'b1;
                    bit_err  = 0;
                    st_err   = 0;
                    done_err = 0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: start at cycle %0d, required none", cyc);
                        fr  = {1'b1, 8'h00, 1'b0};
                        div = 434;
                    end else begin
                        e   = sb.pop_front();
                        fr  = {1'b1, e.data, 1'b0};
                        div = e.div;
                        check("start_edge", start, e.start);
                    end
                end
                if (in_frame) begin
                    j = cyc - start;
                    if (j < 10 * div) begin
                        if (tb_if.uart_tx !== fr[j / div]) bit_err++;
                        if (tb_if.uart_state !== 1'b1) st_err++;
                        if (tb_if.tx_done !== (j == 10 * div - 1)) done_err++;
                    end else begin
                        check("frame_bits", bit_err, 0);
                        check("frame_state", st_err, 0);
                        check("frame_done", done_err, 0);
                        check("post_frame", int'({tb_if.uart_tx, tb_if.uart_state, tb_if.tx_done}), 4);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int d0;
        vecs[0] = '{3'd4, 8'hA5, 434};
        vecs[1] = '{3'd0, 8'h00, 5208};
        vecs[2] = '{3'd6, 8'h3C, 434};
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'hEE;
        tb_if.send_en  = 1'b0;
        tb_if.baud_set = 3'd4;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", int'(tb_if.uart_tx), 1);
        check("rst_tx_done", int'(tb_if.tx_done), 0);
        check("rst_uart_state", int'(tb_if.uart_state), 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            send_pulse(vecs[i].baud, vecs[i].data, vecs[i].div, n);
            wait_done(10 * vecs[i].div + 20, "vec_done");
            repeat (5) @(negedge clk);
        end

        // Held request fed from the model RAM: starts 4340+3 apart.
        use_ram = 1'b1;
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        @(negedge clk);
        tb_if.baud_set = 3'd4;
        tb_if.send_en  = 1'b1;
        n = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{ram[k], 434, n + 1 + k * 4343});
        end
        for (int k = 0; k < 3; k++) begin
            wait_done(4340 + 20, "burst_done");
        end
        tb_if.send_en = 1'b0;
        repeat (20) @(negedge clk);
        use_ram = 1'b0;
        ram_clr = 1'b1;

        // Inputs changed mid-frame must not disturb the latched byte and rate.
        send_pulse(3'd4, 8'h96, 434, n);
        repeat (100) @(negedge clk);
        tb_if.baud_set = 3'd0;
        drv_data       = 8'h00;
        wait_done(4340 + 20, "latch_done");
        repeat (5) @(negedge clk);

        // Reset mid-frame aborts; the next request runs a clean frame.
        send_pulse(3'd4, 8'h5A, 434, n);
        repeat (2000) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("abort_uart_tx", int'(tb_if.uart_tx), 1);
        check("abort_tx_done", int'(tb_if.tx_done), 0);
        check("abort_uart_state", int'(tb_if.uart_state), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_pulse(3'd4, 8'hC3, 434, n);
        check("abort_no_done", done_cnt, d0);
        wait_done(4340 + 20, "post_reset_done");
        repeat (10) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter GUARD, default 3, minimum idle clocks between a tx_done pulse and the next accepted start.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 send_en  input  1  transmit request; a level, and may be held high across many bytes.
REQ-006 data_byte  input  8  byte to send, from the dual-port RAM read port.
REQ-007 baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 select 115200.
REQ-008 uart_tx  output  1  serial line; idle high.
REQ-009 tx_done  output  1  one-clock pulse at the end of each frame.
REQ-010 uart_state  output  1  high while a frame is in progress.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1), with no parity.
REQ-012 Bit period SHALL be DIV clocks, with DIV = CLK_FREQ/baud: 5208, 2604, 1302, 868 or 434 at 50 MHz; the divider counter is 13 bits and counts 0..DIV-1.
REQ-013 The FSM SHALL have states IDLE, GUARD_WAIT and SHIFT.
  - IDLE to SHIFT when send_en=1 is sampled at edge N.
  - SHIFT to GUARD_WAIT after the stop bit.
  - GUARD_WAIT to IDLE after GUARD clocks.
REQ-014 At the accepting edge N, the block SHALL latch data_byte and the DIV derived from baud_set; later changes to either input SHALL NOT affect the current frame.
REQ-015 uart_tx SHALL be registered and glitch-free; the start bit appears at edge N+1, and bit k (0..9) occupies edges N+1+k*DIV through N+(k+1)*DIV.
REQ-016 tx_done SHALL be high for exactly one clock, registered at edge N+10*DIV, coincident with the last clock of the stop bit.
REQ-017 uart_state SHALL be high from edge N+1 through edge N+10*DIV and low from N+10*DIV+1.
REQ-018 send_en SHALL be ignored in SHIFT and GUARD_WAIT, including deassertion mid-frame; a started frame always completes.
REQ-019 With send_en held high, the earliest next start SHALL be sampled at edge N+10*DIV+GUARD, so the upstream read address (+1 clock) and RAM output (+1 clock) have settled.
REQ-020 The block SHALL NOT buffer requests; a send_en pulse that falls entirely outside IDLE is lost.
REQ-021 At 115200 baud the block SHALL sustain 96 back-to-back bytes with no line glitch between frames; the line stays high during GUARD_WAIT.

Reset
REQ-022 Asserting reset SHALL immediately set uart_tx=1, tx_done=0, uart_state=0, the FSM to IDLE, and all counters and the shift register to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame, with no tx_done pulse.
REQ-024 After reset deasserts, the first start SHALL be accepted at the first edge on which send_en=1 is sampled.

Structure
REQ-025 The shared package uart_pkg SHALL hold:
  - the baud enumeration for codes 0..4;
  - the five DIV constants at 50 MHz;
  - the frame length of 10 bits;
  - the FSM state typedef.
REQ-026 A sub-module uart_baud_div SHALL provide the DIV counter and a bit_tick strobe; the shifter and FSM stay in uart_byte_tx.
REQ-027 Target size is 120-250 lines of RTL.

Verification
REQ-028 baud_set=4, data_byte=8'hA5, one-clock send_en pulse -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 434 clocks, and tx_done at N+4340.
REQ-029 baud_set=0, data_byte=8'h00 -> every bit exactly 5208 clocks, and uart_state high for 52080 clocks.
REQ-030 send_en held high, 3 bytes 8'h01/8'h02/8'h03 from a model RAM with address increment on tx_done -> three frames, start edges exactly 4340+3 apart, and the correct bytes received.
REQ-031 data_byte and baud_set changed at N+100 -> the frame still carries the byte and rate latched at N.
REQ-032 reset pulsed at N+2000 -> uart_tx=1 at once, no tx_done; a new send_en afterwards gives a normal full frame.
REQ-033 baud_set=6 -> bit period of 434 clocks.
